// File: rtl/vgpr_operand_fetch_pkg.sv
// Shared VGPR geometry and operand-fetch FSM encoding.
// Imported by the operand-fetch top, its interface and the per-source slot.
package vgpr_operand_fetch_pkg;

    localparam int VGPR_ADDR_W = 10;
    localparam int VGPR_DATA_W = 32;
    localparam int VGPR_NUM_RD = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LO = 3'd1,
        ST_ISSUE_HI = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_OUT      = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/vgpr_operand_fetch_if.sv
// Request (issue side) and operand (ALU side) handshakes of the VGPR operand fetcher.
// The fetcher connects through the slave modport; issue/ALU models use master.
interface vgpr_operand_fetch_if
    import vgpr_operand_fetch_pkg::*;
#(
    parameter int ADDR_W = VGPR_ADDR_W,
    parameter int DATA_W = VGPR_DATA_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3*ADDR_W-1:0]   req_src_addr;
    logic [2:0]            req_src_vld;
    logic [2:0]            req_src_wide;
    logic                  op_valid;
    logic                  op_ready;
    logic [2*DATA_W-1:0]   op_data0;
    logic [2*DATA_W-1:0]   op_data1;
    logic [2*DATA_W-1:0]   op_data2;

    modport master (
        output req_valid, req_src_addr, req_src_vld, req_src_wide, op_ready,
        input  req_ready, op_valid, op_data0, op_data1, op_data2
    );

    modport slave (
        input  req_valid, req_src_addr, req_src_vld, req_src_wide, op_ready,
        output req_ready, op_valid, op_data0, op_data1, op_data2
    );
endinterface

// File: rtl/vgpr_operand_fetch_slot.sv
// One operand source: latched address/mask, read-address mux and low/high word capture.
// With VGPR_OPERAND_FWD_EN defined, snooped VGPR writes override in-flight words.
module vgpr_operand_fetch_slot
    import vgpr_operand_fetch_pkg::*;
#(
    parameter int ADDR_W = VGPR_ADDR_W,
    parameter int DATA_W = VGPR_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                latch,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic                src_vld,
    input  logic                src_wide,
    input  logic                issue_lo,
    input  logic                issue_hi,
    input  logic                cap_lo,
    input  logic                cap_hi,
    input  logic                op_done,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                is_wide,
    output logic [2*DATA_W-1:0] op_data
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_hi;
    logic              vld_q;
    logic              wide_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;

    // Natural ADDR_W-bit overflow gives the 1023 -> 0 wrap.
    assign addr_hi = addr_q + ADDR_W'(1);
    assign is_wide = vld_q & wide_q;
    assign op_data = {hi_q, lo_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            vld_q  <= 1'b0;
            wide_q <= 1'b0;
        end else if (latch) begin
            addr_q <= src_addr;
            vld_q  <= src_vld;
            wide_q <= src_wide;
        end
    end

    always_comb begin
        rd_addr = '0;
        if (issue_lo && vld_q)
            rd_addr = addr_q;
        else if (issue_hi && is_wide)
            rd_addr = addr_hi;
    end

`ifdef VGPR_OPERAND_FWD_EN
    logic lo_armed_q, hi_armed_q;
    logic lo_fwd_q, hi_fwd_q;
    logic lo_hit, hi_hit;

    // A word is exposed to snooped writes from its issue cycle until the ALU takes it.
    assign lo_hit = wr_en && vld_q  && (issue_lo || lo_armed_q) && (wr_addr == addr_q);
    assign hi_hit = wr_en && is_wide && (issue_hi || hi_armed_q) && (wr_addr == addr_hi);

    always_ff @(posedge clk) begin
        if (rst || latch) begin
            lo_q       <= '0;
            hi_q       <= '0;
            lo_armed_q <= 1'b0;
            hi_armed_q <= 1'b0;
            lo_fwd_q   <= 1'b0;
            hi_fwd_q   <= 1'b0;
        end else begin
            if (op_done) begin
                lo_armed_q <= 1'b0;
                hi_armed_q <= 1'b0;
            end else begin
                if (issue_lo && vld_q)   lo_armed_q <= 1'b1;
                if (issue_hi && is_wide) hi_armed_q <= 1'b1;
            end
            // Once forwarded, the registered read may be stale; keep the written value.
            if (lo_hit) begin
                lo_q     <= wr_data;
                lo_fwd_q <= 1'b1;
            end else if (cap_lo && vld_q && !lo_fwd_q) begin
                lo_q <= rd_data;
            end
            if (hi_hit) begin
                hi_q     <= wr_data;
                hi_fwd_q <= 1'b1;
            end else if (cap_hi && is_wide && !hi_fwd_q) begin
                hi_q <= rd_data;
            end
        end
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{wr_en, wr_addr, wr_data, op_done};

    always_ff @(posedge clk) begin
        if (rst || latch) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            if (cap_lo && vld_q)   lo_q <= rd_data;
            if (cap_hi && is_wide) hi_q <= rd_data;
        end
    end
`endif

endmodule

// File: rtl/vgpr_operand_fetch.sv
// Operand fetch FSM in front of the 3R/1W VGPR file; optional write snooping under
// VGPR_OPERAND_FWD_EN (handled inside vgpr_operand_fetch_slot).
//   state    | meaning
//   IDLE     | ready for a request, no operand pending
//   ISSUE_LO | low-word read addresses on rd*_addr
//   ISSUE_HI | high-word (addr+1) addresses for wide sources; low words captured
//   DRAIN    | last read data captured (high words if wide, else low words)
//   OUT      | operands presented to the ALU until op_ready
module vgpr_operand_fetch
    import vgpr_operand_fetch_pkg::*;
#(
    parameter int ADDR_W = VGPR_ADDR_W,
    parameter int DATA_W = VGPR_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    vgpr_operand_fetch_if.slave bus,
    output logic [ADDR_W-1:0]   rd0_addr,
    output logic [ADDR_W-1:0]   rd1_addr,
    output logic [ADDR_W-1:0]   rd2_addr,
    input  logic [DATA_W-1:0]   rd0_data,
    input  logic [DATA_W-1:0]   rd1_data,
    input  logic [DATA_W-1:0]   rd2_data,
    input  logic                wr0_en,
    input  logic [ADDR_W-1:0]   wr0_addr,
    input  logic [DATA_W-1:0]   wr0_data,
    output logic                busy
);

    fetch_state_t state_q, state_d;

    logic [DATA_W-1:0]   rd_data_a [VGPR_NUM_RD];
    logic [ADDR_W-1:0]   rd_addr_a [VGPR_NUM_RD];
    logic [2*DATA_W-1:0] op_data_a [VGPR_NUM_RD];
    logic [VGPR_NUM_RD-1:0] wide_a;

    logic latch, issue_lo, issue_hi, cap_lo, cap_hi, op_done, any_wide;

    assign rd_data_a[0] = rd0_data;
    assign rd_data_a[1] = rd1_data;
    assign rd_data_a[2] = rd2_data;
    assign rd0_addr     = rd_addr_a[0];
    assign rd1_addr     = rd_addr_a[1];
    assign rd2_addr     = rd_addr_a[2];
    assign bus.op_data0 = op_data_a[0];
    assign bus.op_data1 = op_data_a[1];
    assign bus.op_data2 = op_data_a[2];

    assign any_wide      = |wide_a;
    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign bus.op_valid  = (state_q == ST_OUT);
    assign busy          = (state_q != ST_IDLE);

    assign latch    = bus.req_valid && bus.req_ready;
    assign issue_lo = (state_q == ST_ISSUE_LO);
    assign issue_hi = (state_q == ST_ISSUE_HI);
    assign cap_lo   = issue_hi || ((state_q == ST_DRAIN) && !any_wide);
    assign cap_hi   = (state_q == ST_DRAIN) && any_wide;
    assign op_done  = bus.op_valid && bus.op_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (latch) state_d = ST_ISSUE_LO;
            ST_ISSUE_LO: state_d = any_wide ? ST_ISSUE_HI : ST_DRAIN;
            ST_ISSUE_HI: state_d = ST_DRAIN;
            ST_DRAIN:    state_d = ST_OUT;
            ST_OUT:      if (op_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < VGPR_NUM_RD; g++) begin : g_slot
        vgpr_operand_fetch_slot #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .latch    (latch),
            .src_addr (bus.req_src_addr[g*ADDR_W +: ADDR_W]),
            .src_vld  (bus.req_src_vld[g]),
            .src_wide (bus.req_src_wide[g]),
            .issue_lo (issue_lo),
            .issue_hi (issue_hi),
            .cap_lo   (cap_lo),
            .cap_hi   (cap_hi),
            .op_done  (op_done),
            .wr_en    (wr0_en),
            .wr_addr  (wr0_addr),
            .wr_data  (wr0_data),
            .rd_data  (rd_data_a[g]),
            .rd_addr  (rd_addr_a[g]),
            .is_wide  (wide_a[g]),
            .op_data  (op_data_a[g])
        );
    end

endmodule

// File: tb/tb_vgpr_operand_fetch.sv
// Self-checking bench for vgpr_operand_fetch: VGPR array model with 1-cycle registered
// reads, directed scenarios, then randomized requests against an operand reference model.
module tb_vgpr_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd0_addr, rd1_addr, rd2_addr;
    logic [31:0] rd0_data, rd1_data, rd2_data;
    logic        wr0_en;
    logic [9:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        busy;

    logic [31:0] mem [1024];
    logic [9:0]  rda [3];

    int total = 0;
    int bad   = 0;

    vgpr_operand_fetch_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    vgpr_operand_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rd0_addr (rd0_addr),
        .rd1_addr (rd1_addr),
        .rd2_addr (rd2_addr),
        .rd0_data (rd0_data),
        .rd1_data (rd1_data),
        .rd2_data (rd2_data),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign rda[0] = rd0_addr;
    assign rda[1] = rd1_addr;
    assign rda[2] = rd2_addr;

    // Registered read: data for the address presented at an edge appears after it.
    always @(posedge clk) begin
        rd0_data <= mem[rd0_addr];
        rd1_data <= mem[rd1_addr];
        rd2_data <= mem[rd2_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_op(input int i);
        case (i)
            0:       return bus.op_data0;
            1:       return bus.op_data1;
            default: return bus.op_data2;
        endcase
    endfunction

    // Full request: expected operands from the memory image at handshake, latency
    // 3/4 cycles, read-address sequence, optional backpressure, then return to idle.
    task automatic run_req(input logic [29:0] addrs, input logic [2:0] vld,
                           input logic [2:0] wide, input int bp);
        logic [63:0] exp_d [3];
        logic [9:0]  al [3];
        logic [9:0]  ah [3];
        logic [9:0]  exp_a;
        bit          anyw;
        int          n;
        anyw = |(vld & wide);
        for (int i = 0; i < 3; i++) begin
            al[i] = addrs[i*10 +: 10];
            ah[i] = al[i] + 10'd1;
            exp_d[i] = vld[i] ? {(wide[i] ? mem[ah[i]] : 32'h0), mem[al[i]]} : 64'h0;
        end
        bus.req_src_addr = addrs;
        bus.req_src_vld  = vld;
        bus.req_src_wide = wide;
        bus.req_valid    = 1'b1;
        bus.op_ready     = 1'b0;
        chk("req_ready_idle", {63'h0, bus.req_ready}, 64'h1);
        step();
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.op_valid && n < 20) begin
            for (int i = 0; i < 3; i++) begin
                exp_a = 10'd0;
                if (n == 1 && vld[i])                   exp_a = al[i];
                else if (n == 2 && anyw && vld[i] && wide[i]) exp_a = ah[i];
                chk("rd_addr", {54'h0, rda[i]}, {54'h0, exp_a});
            end
            chk("busy_op", {63'h0, busy}, 64'h1);
            step();
            n++;
        end
        chk("latency", 64'(n), anyw ? 64'd4 : 64'd3);
        for (int i = 0; i < 3; i++) chk("op_data", get_op(i), exp_d[i]);
        for (int k = 0; k < bp; k++) begin
            chk("bp_valid", {63'h0, bus.op_valid}, 64'h1);
            chk("bp_req_ready", {63'h0, bus.req_ready}, 64'h0);
            chk("bp_data0", bus.op_data0, exp_d[0]);
            step();
        end
        bus.op_ready = 1'b1;
        chk("out_valid", {63'h0, bus.op_valid}, 64'h1);
        step();
        bus.op_ready = 1'b0;
        chk("post_valid", {63'h0, bus.op_valid}, 64'h0);
        chk("post_req_ready", {63'h0, bus.req_ready}, 64'h1);
        chk("post_busy", {63'h0, busy}, 64'h0);
    endtask

    initial begin
        logic [31:0] old10;
        logic [63:0] exp_fwd;
        int          n;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b1;
        wr0_en = 1'b0;
        wr0_addr = '0;
        wr0_data = '0;
        bus.req_valid = 1'b0;
        bus.req_src_addr = '0;
        bus.req_src_vld = '0;
        bus.req_src_wide = '0;
        bus.op_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", {63'h0, bus.req_ready}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_op_valid", {63'h0, bus.op_valid}, 64'h0);
        chk("rst_op_data0", bus.op_data0, 64'h0);
        chk("rst_op_data2", bus.op_data2, 64'h0);
        chk("rst_rd0_addr", {54'h0, rd0_addr}, 64'h0);
        rst = 1'b0;
        #1;
        chk("rel_req_ready", {63'h0, bus.req_ready}, 64'h1);

        // Narrow request, VGPR[i] = i*3
        mem[5] = 32'd15; mem[6] = 32'd18; mem[7] = 32'd21;
        run_req({10'd7, 10'd6, 10'd5}, 3'b111, 3'b000, 0);
        chk("narrow_d0", bus.op_data0, 64'd15);
        chk("narrow_d2", bus.op_data2, 64'd21);

        // Wide at the top of the file wraps to word 0
        mem[1023] = 32'hAAAA_1111; mem[0] = 32'hBBBB_2222;
        run_req({10'd0, 10'd0, 10'd1023}, 3'b001, 3'b001, 0);
        chk("wrap_d0", bus.op_data0, 64'hBBBB_2222_AAAA_1111);
        chk("wrap_d1", bus.op_data1, 64'h0);

        // Backpressure and sparse mask
        run_req({10'd300, 10'd200, 10'd100}, 3'b111, 3'b010, 5);
        run_req({10'd33, 10'd22, 10'd11}, 3'b010, 3'b111, 2);
        chk("sparse_d0", bus.op_data0, 64'h0);
        chk("sparse_d2", bus.op_data2, 64'h0);

        // Write to an operand word during its issue cycle
        old10 = mem[10];
        bus.req_src_addr = {10'd0, 10'd0, 10'd10};
        bus.req_src_vld  = 3'b001;
        bus.req_src_wide = 3'b000;
        bus.req_valid    = 1'b1;
        step();
        bus.req_valid = 1'b0;
        wr0_en = 1'b1; wr0_addr = 10'd10; wr0_data = 32'h0000_DEAD;
        step();
        wr0_en = 1'b0;
        mem[10] = 32'h0000_DEAD;
        n = 2;
        while (!bus.op_valid && n < 20) begin step(); n++; end
        chk("fwd_latency", 64'(n), 64'd3);
`ifdef VGPR_OPERAND_FWD_EN
        exp_fwd = 64'h0000_DEAD;
`else
        exp_fwd = {32'h0, old10};
`endif
        chk("fwd_d0", bus.op_data0, exp_fwd);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;

        // Reset while in DRAIN drops the request
        bus.req_src_addr = {10'd3, 10'd2, 10'd1};
        bus.req_src_vld  = 3'b111;
        bus.req_valid    = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_valid", {63'h0, bus.op_valid}, 64'h0);
        chk("midrst_data1", bus.op_data1, 64'h0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_no_stray", {63'h0, bus.op_valid}, 64'h0);
        end
        run_req({10'd3, 10'd2, 10'd1}, 3'b111, 3'b100, 1);

        // Randomized requests
        for (int t = 0; t < 30; t++) begin
            run_req(30'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
